// File: rtl/acl_thresh_cfg_pkg.sv
// Shared types and defaults for the ADXL362 threshold preset sequencer.
// The parameter defaults hold the register map and the 10 ms step timeout at 20 MHz.
package acl_thresh_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PAUSE     = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_FINISH    = 3'd4,
    ST_ERROR     = 3'd5
  } t_thrcfg_state;

  localparam logic [7:0]  c_addr_thresh_act_l  = 8'h20;
  localparam logic [7:0]  c_addr_time_inact_l  = 8'h25;
  localparam logic [7:0]  c_addr_act_inact_ctl = 8'h27;
  localparam logic [7:0]  c_act_inact_ctl_val  = 8'h3F;
  localparam logic [19:0] c_timeout_cycles     = 20'd200000;

  localparam int          c_thrcfg_byte_count  = 5;
  localparam logic [2:0]  c_thrcfg_last_idx    = 3'(c_thrcfg_byte_count - 1);

endpackage

// File: rtl/acl_thresh_config_sequencer.sv
// Pauses the accelerometer driver and writes the selected threshold preset as a
// fixed 5-byte register sequence, reporting done, or error on a per-step timeout.
module acl_thresh_config_sequencer
  import acl_thresh_cfg_pkg::*;
#(
  parameter logic [7:0]  parm_addr_thresh_act_l  = c_addr_thresh_act_l,
  parameter logic [7:0]  parm_addr_time_inact_l  = c_addr_time_inact_l,
  parameter logic [7:0]  parm_addr_act_inact_ctl = c_addr_act_inact_ctl,
  parameter logic [7:0]  parm_act_inact_ctl_val  = c_act_inact_ctl_val,
  parameter logic [19:0] parm_timeout_cycles     = c_timeout_cycles
) (
  input  logic        i_clk_20mhz,
  input  logic        i_rst_20mhz,
  input  logic [3:0]  i_value_enum,
  input  logic [15:0] i_value_thresh,
  input  logic [15:0] i_value_timer,
  output logic        o_pause_req,
  input  logic        i_pause_ack,
  output logic        o_wr_valid,
  output logic [7:0]  o_wr_addr,
  output logic [7:0]  o_wr_data,
  input  logic        i_wr_ready,
  input  logic        i_wr_done,
  output logic        o_cfg_busy,
  output logic        o_cfg_done,
  output logic        o_cfg_error,
  output logic        o_cfg_fault,
  output logic [3:0]  o_applied_enum,
  output logic [2:0]  o_dbg_state
);

  // Handshakes: o_pause_req is held until i_pause_ack is seen high; a write command
  // transfers in the cycle o_wr_valid && i_wr_ready, with addr/data held stable
  // until then; i_wr_done only counts once the command has transferred.

  t_thrcfg_state state, state_next;
  logic          pending;
  logic [3:0]    enum_q;
  logic [3:0]    shadow_enum;
  logic [10:0]   shadow_thresh;
  logic [15:0]   shadow_timer;
  logic [2:0]    idx;
  logic [19:0]   tmo_cnt;
  logic [3:0]    applied_enum;
  logic          fault;
  logic          run;
  logic          timed_out;
  logic          enum_change;
  logic [7:0]    tbl_addr;
  logic [7:0]    tbl_data;
  logic          thresh_unused;

  assign thresh_unused = ^i_value_thresh[15:11];
  assign enum_change   = (i_value_enum != enum_q);
  assign run           = (state == ST_PAUSE) || (state == ST_ISSUE) || (state == ST_WAIT_DONE);
  assign timed_out     = (tmo_cnt >= parm_timeout_cycles);

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (pending) state_next = ST_PAUSE;
      ST_PAUSE: begin
        if (i_pause_ack)    state_next = ST_ISSUE;
        else if (timed_out) state_next = ST_ERROR;
      end
      ST_ISSUE: begin
        if (i_wr_ready)     state_next = ST_WAIT_DONE;
        else if (timed_out) state_next = ST_ERROR;
      end
      ST_WAIT_DONE: begin
        if (i_wr_done)      state_next = (idx == c_thrcfg_last_idx) ? ST_FINISH : ST_ISSUE;
        else if (timed_out) state_next = ST_ERROR;
      end
      ST_FINISH:    state_next = ST_IDLE;
      ST_ERROR:     state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    tbl_addr = 8'h00;
    tbl_data = 8'h00;
    case (idx)
      3'd0: begin tbl_addr = parm_addr_thresh_act_l;         tbl_data = shadow_thresh[7:0]; end
      3'd1: begin tbl_addr = parm_addr_thresh_act_l + 8'd1;  tbl_data = {5'b0, shadow_thresh[10:8]}; end
      3'd2: begin tbl_addr = parm_addr_time_inact_l;         tbl_data = shadow_timer[7:0]; end
      3'd3: begin tbl_addr = parm_addr_time_inact_l + 8'd1;  tbl_data = shadow_timer[15:8]; end
      3'd4: begin tbl_addr = parm_addr_act_inact_ctl;        tbl_data = parm_act_inact_ctl_val; end
      default: begin tbl_addr = 8'h00;                       tbl_data = 8'h00; end
    endcase
  end

  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) begin
      state         <= ST_IDLE;
      pending       <= 1'b1;
      enum_q        <= i_value_enum;
      shadow_enum   <= 4'h0;
      shadow_thresh <= 11'h000;
      shadow_timer  <= 16'h0000;
      idx           <= 3'd0;
      tmo_cnt       <= 20'd0;
      applied_enum  <= 4'h0;
      fault         <= 1'b0;
    end else begin
      state  <= state_next;
      enum_q <= i_value_enum;

      // A change seen in the same cycle the FSM leaves idle must re-arm, not be lost.
      if (enum_change)
        pending <= 1'b1;
      else if ((state == ST_IDLE) && (state_next != ST_IDLE))
        pending <= 1'b0;

      if ((state == ST_IDLE) && pending) begin
        shadow_enum   <= i_value_enum;
        shadow_thresh <= i_value_thresh[10:0];
        shadow_timer  <= i_value_timer;
        idx           <= 3'd0;
      end else if ((state == ST_WAIT_DONE) && i_wr_done && (idx != c_thrcfg_last_idx)) begin
        idx <= idx + 3'd1;
      end

      if (state_next != state)
        tmo_cnt <= 20'd0;
      else if (run)
        tmo_cnt <= tmo_cnt + 20'd1;

      if (state == ST_FINISH) begin
        applied_enum <= shadow_enum;
        fault        <= 1'b0;
      end else if (state == ST_ERROR) begin
        fault <= 1'b1;
      end
    end
  end

  assign o_pause_req    = run;
  assign o_cfg_busy     = run || (state == ST_FINISH) || (state == ST_ERROR);
  assign o_wr_valid     = (state == ST_ISSUE);
  assign o_wr_addr      = (state == ST_ISSUE) ? tbl_addr : 8'h00;
  assign o_wr_data      = (state == ST_ISSUE) ? tbl_data : 8'h00;
  assign o_cfg_done     = (state == ST_FINISH);
  assign o_cfg_error    = (state == ST_ERROR);
  assign o_cfg_fault    = fault;
  assign o_applied_enum = applied_enum;
  assign o_dbg_state    = state;

endmodule

// File: tb/tb_acl_thresh_config_sequencer.sv
// Directed bench for the threshold preset sequencer: a driver responder feeds
// ack/ready/done while a scoreboard queue holds the register writes each preset should produce.
module tb_acl_thresh_config_sequencer;
  import acl_thresh_cfg_pkg::*;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [3:0]  i_value_enum;
  logic [15:0] i_value_thresh;
  logic [15:0] i_value_timer;
  logic        i_pause_ack = 1'b0;
  logic        i_wr_ready  = 1'b0;
  logic        i_wr_done   = 1'b0;
  logic        o_pause_req, o_wr_valid, o_cfg_busy, o_cfg_done, o_cfg_error, o_cfg_fault;
  logic [7:0]  o_wr_addr, o_wr_data;
  logic [3:0]  o_applied_enum;
  logic [2:0]  o_dbg_state;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  // Responder knobs (written only by the stimulus block)
  logic ack_en    = 1'b1;
  logic ready_en  = 1'b1;
  logic done_en   = 1'b1;
  int   stall_len = 0;
  // Responder state (written only by the responder)
  int   stall_taken = 0;
  logic stalling    = 1'b0;
  logic xfer_q      = 1'b0;

  acl_thresh_config_sequencer #(.parm_timeout_cycles(20'd100)) dut (
    .i_clk_20mhz   (clk),
    .i_rst_20mhz   (i_rst),
    .i_value_enum  (i_value_enum),
    .i_value_thresh(i_value_thresh),
    .i_value_timer (i_value_timer),
    .o_pause_req   (o_pause_req),
    .i_pause_ack   (i_pause_ack),
    .o_wr_valid    (o_wr_valid),
    .o_wr_addr     (o_wr_addr),
    .o_wr_data     (o_wr_data),
    .i_wr_ready    (i_wr_ready),
    .i_wr_done     (i_wr_done),
    .o_cfg_busy    (o_cfg_busy),
    .o_cfg_done    (o_cfg_done),
    .o_cfg_error   (o_cfg_error),
    .o_cfg_fault   (o_cfg_fault),
    .o_applied_enum(o_applied_enum),
    .o_dbg_state   (o_dbg_state)
  );

  // Clock and watchdog
  always #25 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected write sequence for a preset, derived from the ADXL362 register map
  task automatic push_seq(input logic [15:0] thresh, input logic [15:0] timer);
    logic [7:0] th_h;
    th_h = {5'b0, thresh[10:8]};
    exp_q.push_back({8'h20, thresh[7:0]});
    exp_q.push_back({8'h21, th_h});
    exp_q.push_back({8'h25, timer[7:0]});
    exp_q.push_back({8'h26, timer[15:8]});
    exp_q.push_back({8'h27, 8'h3F});
  endtask

  function automatic logic sig(input int which, input logic [7:0] addr);
    case (which)
      0:       return o_cfg_done;
      1:       return o_cfg_error;
      2:       return o_pause_req;
      default: return o_wr_valid && (o_wr_addr == addr);
    endcase
  endfunction

  // Wait on negedges for a DUT event; cyc counts the current cycle as 1.
  task automatic wait_sig(input string tag, input int which, input logic [7:0] addr,
                          input int max, output int cyc);
    cyc = 1;
    while (!sig(which, addr) && cyc < max) begin
      @(negedge clk);
      cyc++;
    end
    check({"wait_", tag}, 32'(sig(which, addr)), 32'd1);
  endtask

  // Driver responder and scoreboard: drives inputs for the next edge, pops on transfer
  always @(negedge clk) begin
    i_wr_done   = done_en && xfer_q;
    i_pause_ack = ack_en;
    if (stall_taken < stall_len && (stalling || (o_wr_valid && o_wr_addr == 8'h25))) begin
      stalling = 1'b1;
      stall_taken++;
      check("stall_valid", 32'(o_wr_valid), 32'd1);
      check("stall_addr", 32'(o_wr_addr), 32'h25);
      check("stall_data", 32'(o_wr_data), 32'hE8);
      i_wr_ready = 1'b0;
    end else begin
      stalling   = 1'b0;
      i_wr_ready = ready_en;
    end
    xfer_q = o_wr_valid && i_wr_ready && !i_rst;
    if (xfer_q) begin
      check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0)
        check("sb_write", 32'({o_wr_addr, o_wr_data}), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    int cyc;
    i_rst = 1'b1;
    i_value_enum = 4'd0;
    i_value_thresh = 16'd300;
    i_value_timer = 16'd1000;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_pause", 32'(o_pause_req), 0);
    check("rst_valid", 32'(o_wr_valid), 0);
    check("rst_busy", 32'(o_cfg_busy), 0);
    check("rst_done", 32'(o_cfg_done), 0);
    check("rst_error", 32'(o_cfg_error), 0);
    check("rst_fault", 32'(o_cfg_fault), 0);
    check("rst_applied", 32'(o_applied_enum), 0);
    check("rst_addr", 32'(o_wr_addr), 0);
    check("rst_data", 32'(o_wr_data), 0);

    // Startup configuration, 12-cycle sequence
    push_seq(16'd300, 16'd1000);
    i_rst = 1'b0;
    check("idle_after_release", 32'(o_pause_req), 0);
    @(negedge clk);
    check("pause_rise", 32'(o_pause_req), 1);
    wait_sig("start_done", 0, 8'h00, 40, cyc);
    check("startup_latency", cyc, 12);
    @(negedge clk);
    check("done_one_cycle", 32'(o_cfg_done), 0);
    check("start_applied", 32'(o_applied_enum), 0);
    check("start_busy", 32'(o_cfg_busy), 0);
    check("start_sb_drained", exp_q.size(), 0);

    // Enum 0->3 with full-scale threshold
    i_value_enum = 4'd3; i_value_thresh = 16'hFFFF; i_value_timer = 16'hA55A;
    push_seq(16'hFFFF, 16'hA55A);
    wait_sig("e3_pause", 2, 8'h00, 10, cyc);
    wait_sig("e3_done", 0, 8'h00, 40, cyc);
    @(negedge clk);
    check("e3_applied", 32'(o_applied_enum), 3);
    check("e3_sb_drained", exp_q.size(), 0);

    // Ready withheld for 50 cycles on the TIME_INACT_L byte
    stall_len = 50;
    i_value_enum = 4'd5; i_value_thresh = 16'd300; i_value_timer = 16'd1000;
    push_seq(16'd300, 16'd1000);
    wait_sig("stall_done", 0, 8'h00, 200, cyc);
    @(negedge clk);
    check("stall_cycles", stall_taken, 50);
    check("stall_applied", 32'(o_applied_enum), 5);
    check("stall_sb_drained", exp_q.size(), 0);

    // Driver never acknowledges the pause: timeout abort
    ack_en = 1'b0;
    i_value_enum = 4'd6; i_value_thresh = 16'h0001; i_value_timer = 16'h0002;
    wait_sig("tmo_pause", 2, 8'h00, 10, cyc);
    wait_sig("tmo_error", 1, 8'h00, 300, cyc);
    check("tmo_window", 32'(cyc >= 100 && cyc <= 103), 1);
    @(negedge clk);
    check("tmo_fault", 32'(o_cfg_fault), 1);
    check("tmo_pause_drop", 32'(o_pause_req), 0);
    check("tmo_error_pulse", 32'(o_cfg_error), 0);
    check("tmo_applied_kept", 32'(o_applied_enum), 5);
    repeat (5) @(negedge clk);
    check("tmo_no_retry", 32'(o_pause_req), 0);
    ack_en = 1'b1;
    i_value_enum = 4'd7; i_value_thresh = 16'h0123; i_value_timer = 16'h4567;
    push_seq(16'h0123, 16'h4567);
    wait_sig("recover_done", 0, 8'h00, 40, cyc);
    @(negedge clk);
    check("recover_fault_clr", 32'(o_cfg_fault), 0);
    check("recover_applied", 32'(o_applied_enum), 7);

    // Enum 1->2 during byte index 3: both sequences run back to back
    i_value_enum = 4'd1; i_value_thresh = 16'h0456; i_value_timer = 16'h789A;
    push_seq(16'h0456, 16'h789A);
    wait_sig("mid_idx3", 3, 8'h26, 40, cyc);
    i_value_enum = 4'd2; i_value_thresh = 16'h07FF; i_value_timer = 16'h0102;
    push_seq(16'h07FF, 16'h0102);
    wait_sig("mid_done1", 0, 8'h00, 40, cyc);
    @(negedge clk);
    check("mid_applied1", 32'(o_applied_enum), 1);
    wait_sig("mid_done2", 0, 8'h00, 40, cyc);
    @(negedge clk);
    check("mid_applied2", 32'(o_applied_enum), 2);
    check("mid_sb_drained", exp_q.size(), 0);

    // Enum change coincident with the finish cycle
    i_value_enum = 4'd8; i_value_thresh = 16'h0005; i_value_timer = 16'h0006;
    push_seq(16'h0005, 16'h0006);
    wait_sig("fin_done1", 0, 8'h00, 40, cyc);
    i_value_enum = 4'd9; i_value_thresh = 16'h0010; i_value_timer = 16'h0020;
    push_seq(16'h0010, 16'h0020);
    @(negedge clk);
    check("fin_idle_gap", 32'(o_pause_req), 0);
    check("fin_applied1", 32'(o_applied_enum), 8);
    @(negedge clk);
    check("fin_restart", 32'(o_pause_req), 1);
    wait_sig("fin_done2", 0, 8'h00, 40, cyc);
    @(negedge clk);
    check("fin_applied2", 32'(o_applied_enum), 9);

    // Reset while waiting for a write to complete
    i_value_enum = 4'd10; i_value_thresh = 16'd300; i_value_timer = 16'd1000;
    push_seq(16'd300, 16'd1000);
    wait_sig("rst_idx1", 3, 8'h21, 40, cyc);
    @(negedge clk);
    check("rst_in_wait", 32'(o_dbg_state), 32'(ST_WAIT_DONE));
    i_rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 32'(o_wr_valid), 0);
    check("mid_rst_pause", 32'(o_pause_req), 0);
    check("mid_rst_busy", 32'(o_cfg_busy), 0);
    check("mid_rst_applied", 32'(o_applied_enum), 0);
    exp_q.delete();
    push_seq(16'd300, 16'd1000);
    @(negedge clk);
    i_rst = 1'b0;
    wait_sig("post_rst_pause", 2, 8'h00, 10, cyc);
    wait_sig("post_rst_done", 0, 8'h00, 40, cyc);
    @(negedge clk);
    check("post_rst_applied", 32'(o_applied_enum), 10);
    check("post_rst_sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acl_thresh_config_sequencer.md
# acl_thresh_config_sequencer

- Pushes the selected threshold preset into the ADXL362 accelerometer registers.
- Sits between the preset selector outputs (enum, 16-bit threshold, 16-bit timer) and the SPI accelerometer driver's register-write command port.
- On reset, and on every change of preset enum, it pauses the driver's measurement loop and issues a fixed 5-byte write sequence. It then reports done, or reports error on timeout.

## Interface
- parm_addr_thresh_act_l, 8'h20, ADXL362 THRESH_ACT_L address
- parm_addr_time_inact_l, 8'h25, TIME_INACT_L address; the H register is at +1
- parm_addr_act_inact_ctl, 8'h27, ACT_INACT_CTL address
- parm_act_inact_ctl_val, 8'h3F, byte written last to re-arm linked/loop detection
- parm_timeout_cycles, 20'd200000, per-step timeout (10 ms at 20 MHz)

Ports:
- i_clk_20mhz  in  1  sole clock
- i_rst_20mhz  in  1  synchronous, active-high reset
- i_value_enum  in  4  preset index from the selector
- i_value_thresh  in  16  preset activity threshold; only [10:0] is used
- i_value_timer  in  16  preset inactivity time
- o_pause_req  out  1  request that the driver stop its measurement loop
- i_pause_ack  in  1  driver is idle and accepting commands
- o_wr_valid  out  1  write command valid
- o_wr_addr  out  8  register address
- o_wr_data  out  8  register data
- i_wr_ready  in  1  driver accepts the command
- i_wr_done  in  1  one-cycle pulse when the SPI write completes
- o_cfg_busy  out  1  sequence in progress
- o_cfg_done  out  1  one-cycle pulse on successful completion
- o_cfg_error  out  1  one-cycle pulse on timeout abort
- o_cfg_fault  out  1  sticky; cleared by the next success or by reset
- o_applied_enum  out  4  enum of the last successfully applied preset

## Operation
States: ST_IDLE, ST_PAUSE, ST_ISSUE, ST_WAIT_DONE, ST_FINISH, ST_ERROR.

Pending flag:
- Set on reset, so the block configures once at startup.
- Set in any cycle where i_value_enum differs from its one-cycle-delayed copy.
- Cleared on leaving ST_IDLE. A change arriving mid-sequence sets it again, so a new sequence starts after the current one ends.

State transitions:
- ST_IDLE: if pending, latch the shadow registers (enum, thresh, timer), clear index to 0, go to ST_PAUSE.
- ST_PAUSE: o_pause_req=1. On i_pause_ack=1, go to ST_ISSUE.
- ST_ISSUE: o_wr_valid=1 with addr/data from the byte table. Addr/data stay stable until i_wr_ready=1 in the same cycle, then go to ST_WAIT_DONE.
- ST_WAIT_DONE: on i_wr_done, go to ST_FINISH if index==4; otherwise increment index and go to ST_ISSUE.
- ST_FINISH (1 cycle):
  - o_cfg_done=1, o_applied_enum←shadow enum, o_cfg_fault←0.
  - Go to ST_IDLE.
- ST_ERROR (1 cycle):
  - o_cfg_error=1, o_cfg_fault←1.
  - o_applied_enum is unchanged.
  - Go to ST_IDLE; no automatic retry unless pending is set again.

Byte table, index 0..4:
- 0: THRESH_ACT_L = thresh[7:0]
- 1: THRESH_ACT_L+1 = {5'b0, thresh[10:8]}
- 2: TIME_INACT_L = timer[7:0]
- 3: TIME_INACT_L+1 = timer[15:8]
- 4: ACT_INACT_CTL = parm_act_inact_ctl_val

Timeout:
- A 20-bit counter reloads on every state entry and runs in ST_PAUSE, ST_ISSUE and ST_WAIT_DONE.
- When it reaches parm_timeout_cycles, the FSM goes to ST_ERROR.

Output decode:
- o_pause_req and o_cfg_busy are high in ST_PAUSE, ST_ISSUE and ST_WAIT_DONE.
- o_cfg_busy is additionally high in ST_FINISH and ST_ERROR.

## Timing
- Reset values: state ST_IDLE, pending=1, index 0, all outputs 0, o_applied_enum 4'h0, o_wr_addr/o_wr_data 8'h00.
- Reset mid-sequence: all outputs return to reset values in the cycle after the reset sample; no partial write is retried.
- Outputs are Moore, decoded from the registered state and shadow registers.
- Startup latency: the cycle after reset deassert is ST_IDLE; o_pause_req rises one cycle later.
- Minimum sequence length, with ack/ready/done all immediate: 1 ST_PAUSE + 5×(ST_ISSUE + ST_WAIT_DONE) + 1 ST_FINISH = 12 cycles.
- i_wr_done arriving while in ST_ISSUE is ignored; only a done seen in ST_WAIT_DONE counts.
- i_value_thresh/timer changes after the latch cycle do not affect bytes in flight.
- Simultaneous enum change and ST_FINISH: the done pulse is still issued and pending is set; the next sequence starts one ST_IDLE cycle later.

## Structure
- Shared package acl_thresh_cfg_pkg holds:
  - the state typedef enum (t_thrcfg_state, 3-bit);
  - localparam register address defaults;
  - c_thrcfg_byte_count = 5.
- Single module; no sub-module. The byte table is a combinational case on the index.

## Test plan
- Reset release with immediate ack/ready/done and thresh=16'd300, timer=16'd1000:
  - writes 20←2C, 21←01, 25←E8, 26←03, 27←3F;
  - o_cfg_done at cycle 12;
  - o_applied_enum=0.
- Enum changes 0→3 with thresh 16'hFFFF: byte 1 is 8'h07, and o_applied_enum=3 after done.
- i_wr_ready held low for 50 cycles in index 2: addr/data stay at 25/E8 throughout; exactly one transfer occurs.
- i_pause_ack never asserted:
  - o_cfg_error pulses after parm_timeout_cycles (override to 100 in the bench);
  - o_cfg_fault=1 and o_pause_req drops;
  - a later enum change with a healthy driver clears the fault.
- Enum changes 1→2 during index 3: the first sequence completes, then a second sequence follows with enum 2's values; o_applied_enum ends at 2.
- Reset asserted in ST_WAIT_DONE: o_wr_valid, o_pause_req and o_cfg_busy are 0 after one cycle; a fresh sequence starts after reset release.
